fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch controller that owns the program counter register and sequences the next-PC datapath. It issues one instruction-memory request per fetch over a req/ack handshake and selects the next PC: sequential PC+4, branch target or jump target. It also handles stall and run/idle control. It sits between the instruction memory and the decode stage, replacing free-running PC/adder clocking with a handshake-driven sequence.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = fetch enabled, 0 = finish in-flight request then idle.
- stall  in  1  level; decode cannot accept; sampled at the ack edge and in STALL.
- imem_req  out  1  fetch request; held until the imem_ack cycle.
- imem_addr  out  32  fetch address; equals PC and is stable while imem_req=1.
- imem_ack  in  1  memory accepted/completed the request this cycle; ignored when imem_req=0.
- instr_valid  out  1  one-cycle pulse: an instruction for instr_pc is delivered.
- instr_pc  out  32  address of the delivered instruction; holds until the next delivery.
- br_taken  in  1  one-cycle pulse from decode: the branch at instr_pc is taken.
- br_offset  in  16  signed word offset of the branch.
- jump  in  1  one-cycle pulse from decode: J-type jump at instr_pc.
- jump_index  in  26  jump word index.
- pc_out  out  32  current PC register.

## Operation
- States: IDLE, FETCH, STALL.
- IDLE: imem_req=0. If run=1, go to FETCH.
- FETCH: imem_req=1 and imem_addr=PC. When imem_ack=1:
  - No redirect pending or arriving: instr_valid=1 next cycle, instr_pc←PC, PC←PC+4.
  - Redirect pending or arriving: fetch is discarded (no instr_valid) and PC←target.
  - Next state: STALL if stall=1; IDLE if run=0; otherwise FETCH.
- STALL: imem_req=0. Return to FETCH when stall=0, or to IDLE if run=0.
- Redirect targets, all arithmetic mod 2^32:
  - Branch: instr_pc + 4 + (sign-extend(br_offset) << 2).
  - Jump: {instr_pc_plus4[31:28], jump_index, 2'b00}.
  - jump has priority over br_taken when both pulse in the same cycle.
  - No delay slot.
- Redirect in FETCH before ack: target is latched into a pending register. imem_addr must not change mid-request. Pending is applied and cleared at ack.
- Redirect in IDLE or STALL: PC←target on the next edge, with no pending.
- A second redirect while one is pending overwrites it (latest wins, jump>branch within a cycle).
- PC+4 wrap: 32'hFFFF_FFFC → 32'h0000_0000.

## Timing
- Reset values (sync): PC=RESET_VECTOR, state=IDLE, imem_req=0, imem_addr=RESET_VECTOR, instr_valid=0, instr_pc=0, pc_out=RESET_VECTOR, pending cleared.
- RESET asserted mid-request drops imem_req the next cycle; reset takes precedence over all inputs.
- run sampled high at edge n → imem_req=1 from cycle n+1.
- Zero-wait memory (ack in the same cycle as req):
  - instr_valid one cycle after ack.
  - Next request issued the cycle after ack with the updated address.
  - Sustained throughput: one instruction per cycle.
- instr_valid is never asserted for a discarded fetch. It is never asserted twice for one ack.
- After an ack with stall=1: ≥1 cycle with imem_req=0. Fetch resumes the cycle after stall is sampled 0.
- Redirect in IDLE/STALL: the next imem_addr issued equals the target.

## Test plan
- Reset then run=1, ack tied 1 → imem_addr 0,4,8,12 on consecutive cycles; instr_valid continuous with instr_pc lagging by 1 cycle.
- ack delayed 3 cycles per request → imem_addr held stable for 4 cycles; exactly one instr_valid per ack.
- instr_pc=0x100, br_taken with br_offset=16'hFFFE, during an un-acked fetch of 0x104 → fetch discarded, next imem_addr=0xFC. Repeat with jump, jump_index=0x0000040, instr_pc=0x1000_0000 → next imem_addr=0x1000_0100.
- Simultaneous jump and br_taken → jump target used.
- stall=1 at ack → imem_req low until stall=0, then resumes at PC+4. Run PC at 0xFFFF_FFFC → next fetch 0x0.
- RESET pulsed while imem_req=1 with ack withheld → next cycle imem_req=0, pc_out=RESET_VECTOR, no instr_valid. A late ack is ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request per fetch over
// req/ack, and applies branch/jump redirects (no delay slot) at the request boundary.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               run,
    input  logic               stall,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    output logic               instr_valid,
    output logic [31:0]        instr_pc,
    input  logic               br_taken,
    input  logic signed [15:0] br_offset,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    output logic [31:0]        pc_out
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        vld_p1, vld_nxt;
    logic [31:0] ipc_p1, ipc_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    logic        redir;
    logic [31:0] redir_tgt;

    // Targets are relative to the delivered instruction, not the PC being fetched.
    function automatic logic [31:0] redirect_target(
        input logic [31:0]        base_pc,
        input logic               is_jump,
        input logic [25:0]        index,
        input logic signed [15:0] offset
    );
        logic [31:0]        seq_pc;
        logic signed [31:0] disp;
        seq_pc = base_pc + 32'd4;
        disp   = {{14{offset[15]}}, offset, 2'b00};
        if (is_jump)
            return {seq_pc[31:28], index, 2'b00};
        else
            return seq_pc + $unsigned(disp);
    endfunction

    always_comb begin
        redir        = jump | br_taken;
        redir_tgt    = redirect_target(ipc_p1, jump, jump_index, br_offset);
        state_nxt    = state;
        pc_nxt       = pc;
        pend_vld_nxt = pend_vld;
        pend_tgt_nxt = pend_tgt;
        vld_nxt      = 1'b0;
        ipc_nxt      = ipc_p1;
        case (state)
            IDLE: begin
                if (redir) pc_nxt = redir_tgt;
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                // The address must stay put until ack, so mid-request redirects wait in pend_*.
                if (imem_ack) begin
                    if (redir) begin
                        pc_nxt = redir_tgt;
                    end else if (pend_vld) begin
                        pc_nxt = pend_tgt;
                    end else begin
                        vld_nxt = 1'b1;
                        ipc_nxt = pc;
                        pc_nxt  = pc + 32'd4;
                    end
                    pend_vld_nxt = 1'b0;
                    if (stall)
                        state_nxt = STALL;
                    else if (!run)
                        state_nxt = IDLE;
                end else if (redir) begin
                    pend_vld_nxt = 1'b1;
                    pend_tgt_nxt = redir_tgt;
                end
            end
            STALL: begin
                if (redir) pc_nxt = redir_tgt;
                if (!run)
                    state_nxt = IDLE;
                else if (!stall)
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: state, PC and delivery registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            pc       <= RESET_VECTOR;
            pend_vld <= 1'b0;
            vld_p1   <= 1'b0;
            ipc_p1   <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            pend_vld <= pend_vld_nxt;
            vld_p1   <= vld_nxt;
            ipc_p1   <= ipc_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        pend_tgt <= pend_tgt_nxt;
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign pc_out      = pc;
    assign instr_valid = vld_p1;
    assign instr_pc    = ipc_p1;
endmodule
